// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory arbiter: memory geometry,
// the nop word returned on rejected addresses, and the read-return owner tags.
package imem_pkg;

    localparam int          DEPTH    = 128;
    localparam int          IDX_W    = $clog2(DEPTH);
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    // owner | meaning
    // NONE  | no read data returns next cycle (idle or ext write)
    // FETCH | fetch read in flight, data returns next cycle
    // EXT_RD| ext read in flight, data returns next cycle
    typedef enum logic [1:0] {
        NONE   = 2'd0,
        FETCH  = 2'd1,
        EXT_RD = 2'd2
    } owner_e;

endpackage

// File: rtl/imem_arbiter.sv
// Per-cycle arbiter sharing one synchronous-read instruction memory between CPU fetch
// and the loader/debug port. Optional address checking under IMEM_ARB_ADDR_CHECK_EN.
module imem_arbiter #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = imem_pkg::DEPTH,
    parameter int IDX_W    = $clog2(DEPTH),
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [31:0]       fetch_addr,
    output logic              fetch_gnt,
    output logic              fetch_rvalid,
    output logic [DATA_W-1:0] fetch_rdata,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [31:0]       ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_gnt,
    output logic              ext_rvalid,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [IDX_W-1:0]  mem_idx,
    output logic [DATA_W-1:0] mem_wdata,
`ifdef IMEM_ARB_ADDR_CHECK_EN
    output logic              addr_err,
`endif
    input  logic [DATA_W-1:0] mem_rdata
);
    import imem_pkg::*;

    localparam int CNT_W = 4;

    logic              starve;
    logic              fetch_err;
    logic              ext_err;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    owner_e            owner_q, owner_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] fetch_hold_q, fetch_hold_d;
    logic [DATA_W-1:0] ext_hold_q, ext_hold_d;
    logic [DATA_W-1:0] ret_word;

`ifdef IMEM_ARB_ADDR_CHECK_EN
    // Misaligned or out-of-range addresses are granted but never reach the memory.
    assign fetch_err = (fetch_addr[1:0] != 2'b00) || (fetch_addr[31:IDX_W+2] != '0);
    assign ext_err   = (ext_addr[1:0] != 2'b00) || (ext_addr[31:IDX_W+2] != '0);
    assign addr_err  = err_q;
`else
    logic unused_addr_bits;
    assign fetch_err        = 1'b0;
    assign ext_err          = 1'b0;
    assign unused_addr_bits = ^{fetch_addr[31:IDX_W+2], fetch_addr[1:0],
                                ext_addr[31:IDX_W+2], ext_addr[1:0]};
`endif

    always_comb begin
        starve    = ext_req && (wait_cnt_q == CNT_W'(MAX_WAIT));
        fetch_gnt = !reset && fetch_req && !starve;
        ext_gnt   = !reset && ext_req && !fetch_gnt;

        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_idx   = '0;
        mem_wdata = '0;
        owner_d   = NONE;
        err_d     = 1'b0;

        if (fetch_gnt) begin
            mem_en  = !fetch_err;
            mem_idx = fetch_err ? '0 : fetch_addr[IDX_W+1:2];
            owner_d = FETCH;
            err_d   = fetch_err;
        end else if (ext_gnt) begin
            mem_en    = !ext_err;
            mem_we    = ext_we && !ext_err;
            mem_idx   = ext_err ? '0 : ext_addr[IDX_W+1:2];
            mem_wdata = ext_err ? '0 : ext_wdata;
            // A rejected ext write still gets a nop response so the loader sees the error.
            owner_d   = (!ext_we || ext_err) ? EXT_RD : NONE;
            err_d     = ext_err;
        end

        if (ext_req && !ext_gnt)
            wait_cnt_d = (wait_cnt_q == CNT_W'(MAX_WAIT)) ? wait_cnt_q : wait_cnt_q + 1'b1;
        else
            wait_cnt_d = '0;

        ret_word     = err_q ? DATA_W'(NOP_WORD) : mem_rdata;
        fetch_rvalid = (owner_q == FETCH);
        ext_rvalid   = (owner_q == EXT_RD);
        fetch_rdata  = fetch_rvalid ? ret_word : fetch_hold_q;
        ext_rdata    = ext_rvalid ? ret_word : ext_hold_q;
        fetch_hold_d = fetch_rdata;
        ext_hold_d   = ext_rdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q   <= '0;
            owner_q      <= NONE;
            err_q        <= 1'b0;
            fetch_hold_q <= '0;
            ext_hold_q   <= '0;
        end else begin
            wait_cnt_q   <= wait_cnt_d;
            owner_q      <= owner_d;
            err_q        <= err_d;
            fetch_hold_q <= fetch_hold_d;
            ext_hold_q   <= ext_hold_d;
        end
    end

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares the single-port 128-word instruction memory between two requesters.
- Requester 1 is the CPU fetch port. Requester 2 is the external loader/debug port, which writes program images and reads memory back.
- The block owns the memory enable, write and address lines. It arbitrates per cycle, routes read data back to the winning requester one cycle later, and prevents the loader from being starved.
- It sits between the datapath PC/fetch logic and a synchronous-read instruction memory.

Parameters:
- DATA_W, 32, instruction/data word width
- DEPTH, 128, memory depth in words (power of 2)
- IDX_W, 7, word index width, equal to log2(DEPTH)
- MAX_WAIT, 4, consecutive cycles a pending ext request may lose before it is forced to win (1..15)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- fetch_req  in  1  fetch read request
- fetch_addr  in  32  byte address; word index = fetch_addr[IDX_W+1:2]
- fetch_gnt  out  1  fetch request accepted this cycle
- fetch_rvalid  out  1  fetch_rdata valid (one cycle after the grant)
- fetch_rdata  out  DATA_W  instruction word
- ext_req  in  1  loader/debug request
- ext_we  in  1  1 = write, 0 = read
- ext_addr  in  32  byte address
- ext_wdata  in  DATA_W  write data
- ext_gnt  out  1  ext request accepted this cycle
- ext_rvalid  out  1  ext_rdata valid (ext reads only)
- ext_rdata  out  DATA_W  read-back word
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_idx  out  IDX_W  memory word index
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, registered inside memory, valid the cycle after mem_en

Behaviour:
- Clock and reset: the block uses the single clock clk. reset is synchronous and active-high.
- Reset values:
  - Registered outputs fetch_rvalid and ext_rvalid are 0.
  - fetch_rdata and ext_rdata are 0.
  - Internal registers: wait_cnt = 0, owner_q = NONE.
- Grant logic (combinational, same cycle as the request):
  - Fetch has priority. If fetch_req=1 and the starve condition is false: fetch_gnt=1, ext_gnt=0.
  - Starve condition: wait_cnt == MAX_WAIT with ext_req=1. When it holds, ext_gnt=1 and fetch_gnt=0. Fetch must hold its request and retry.
  - If only ext_req=1: ext_gnt=1.
  - At most one grant per cycle.
- Memory drive:
  - mem_en = fetch_gnt | ext_gnt.
  - mem_we = ext_gnt & ext_we.
  - mem_idx and mem_wdata come from the granted requester.
  - With no grant: mem_idx=0 and mem_wdata=0.
- wait_cnt:
  - Increments (saturating at MAX_WAIT) each cycle that ext_req=1 and ext_gnt=0.
  - Clears on ext_gnt or when ext_req=0.
- owner_q register: records FETCH, EXT_RD or NONE each cycle. Ext writes record NONE.
- Read return (1-cycle latency):
  - fetch_rvalid = (owner_q == FETCH).
  - ext_rvalid = (owner_q == EXT_RD).
  - The owning requester's rdata equals mem_rdata that cycle. The non-owner's rdata holds its last value.
- Writes: an ext write completes in the grant cycle. A fetch of the same index in the next cycle returns the new word (read-after-write ordering through the memory).
- Back-to-back grants to alternating requesters are allowed every cycle.
- Reset mid-operation: an in-flight rvalid is squashed the next cycle, wait_cnt clears, and no grant is issued while reset=1.

Optional Feature:
- Macro: IMEM_ARB_ADDR_CHECK_EN
- When defined:
  - A request whose address has addr[1:0]!=0 or addr[31:IDX_W+2]!=0 is granted but does not drive mem_en.
  - One cycle later the requester's rvalid pulses with rdata = 32'h0000_0000 (a MIPS nop).
  - An extra output addr_err (1 bit, reset 0) pulses in the same cycle.
- When undefined: upper and low address bits are ignored and truncated to the index, and the addr_err port is absent.

Decomposition:
- Shared package imem_pkg holds:
  - owner enum {NONE, FETCH, EXT_RD}
  - DEPTH/IDX_W constants
  - the NOP_WORD constant (32'h0)
- No sub-module. The starvation counter is small enough to stay inline.

Test Plan:
- Fetch only, fetch_addr=0x0000_0008 every cycle, mem word 2 = 0x2002_0005 -> fetch_gnt=1 each cycle; next cycle fetch_rvalid=1, fetch_rdata=0x2002_0005.
- Ext write idx 3 = 0xDEAD_BEEF, then fetch 0x0000_000C the next cycle -> fetch_rdata=0xDEAD_BEEF.
- fetch_req and ext_req held high together (ext read of 0x10) -> fetch wins for 4 cycles; cycle 5 ext_gnt=1 and fetch_gnt=0; cycle 6 ext_rvalid=1; wait_cnt back to 0.
- ext_req alone, read 0x0000_01FC -> ext_rvalid one cycle later with the word at idx 127; fetch_rvalid stays 0.
- Reset asserted in the cycle after a fetch grant -> fetch_rvalid=0 the following cycle and all outputs at reset values.
- With IMEM_ARB_ADDR_CHECK_EN defined, fetch 0x0000_0202 -> mem_en=0; next cycle fetch_rvalid=1, fetch_rdata=0, addr_err=1.
